icache: RTL and testbench

Two-way set-associative instruction cache between the fetch stage and instruction memory.
- Read side: the fetch stage presents a registered read address and gets a same-cycle hit flag and instruction word, so a hit finishes fetch without any memory-bus bytes.
- Write side: after a miss, the fetch stage assembles the instruction from memory bytes and fills the cache through a one-cycle write strobe.
- A flush input invalidates the whole cache in one cycle (fence.i / program reload).

---
 rtl/icache.sv | 90 +++++++++
 tb/tb_icache.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Two-way set-associative instruction cache: combinational lookup, single-cycle fill,
// one-cycle flush, one LRU bit per set.
module icache #(
  parameter int unsigned SETS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        we_i,
  input  logic [31:0] waddr_i,
  input  logic [31:0] winst_i,
  input  logic [31:0] raddr_i,
  output logic        hit_o,
  output logic [31:0] inst_o
);

  localparam int unsigned IDX = $clog2(SETS);
  localparam int unsigned TW  = 30 - IDX;

  logic [SETS-1:0] valid0, valid1, lru;
  logic [TW-1:0]   tag0  [SETS];
  logic [TW-1:0]   tag1  [SETS];
  logic [31:0]     data0 [SETS];
  logic [31:0]     data1 [SETS];

  logic [IDX-1:0] ridx, widx;
  logic [TW-1:0]  rtag, wtag;
  logic           hit0, hit1;
  logic           match0, match1;
  logic           victim;
  logic           unused_bits;

  assign ridx = raddr_i[IDX+1:2];
  assign rtag = raddr_i[31:IDX+2];
  assign widx = waddr_i[IDX+1:2];
  assign wtag = waddr_i[31:IDX+2];
  assign unused_bits = ^{raddr_i[1:0], waddr_i[1:0]};

  // Lookup; way 0 wins if both ways ever hit
  always_comb begin
    hit0   = valid0[ridx] && (tag0[ridx] == rtag);
    hit1   = valid1[ridx] && (tag1[ridx] == rtag);
    hit_o  = hit0 || hit1;
    inst_o = 32'h0;
    if (hit0)      inst_o = data0[ridx];
    else if (hit1) inst_o = data1[ridx];
  end

  // Victim: existing line with same tag, then first invalid way, then LRU way
  always_comb begin
    match0 = valid0[widx] && (tag0[widx] == wtag);
    match1 = valid1[widx] && (tag1[widx] == wtag);
    victim = lru[widx];
    if (match0)            victim = 1'b0;
    else if (match1)       victim = 1'b1;
    else if (!valid0[widx]) victim = 1'b0;
    else if (!valid1[widx]) victim = 1'b1;
  end

  // Valid and LRU state: flush beats fill, fill owns the LRU bit of its set
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      if (we_i) begin
        if (victim) valid1[widx] <= 1'b1;
        else        valid0[widx] <= 1'b1;
        lru[widx] <= ~victim;
      end
      if (hit_o && !(we_i && (widx == ridx)))
        lru[ridx] <= hit0 ? 1'b1 : 1'b0;
    end
  end

  // Tag/data arrays carry no reset; a dropped fill leaves them untouched
  always_ff @(posedge clk) begin
    if (we_i && !rst && !flush_i) begin
      if (victim) begin
        tag1[widx]  <= wtag;
        data1[widx] <= winst_i;
      end else begin
        tag0[widx]  <= wtag;
        data0[widx] <= winst_i;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus random traffic checked against a
// recency-ordered per-set model (slot 0 = least recently used).
module tb_icache;
  localparam int unsigned SETS = 64;
  localparam logic [31:0] IDLE = 32'h0000_0004;

  logic        clk = 1'b0;
  logic        rst, flush_i, we_i, hit_o;
  logic [31:0] waddr_i, winst_i, raddr_i, inst_o;

  always #5 clk = ~clk;

  icache #(.SETS(SETS)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .we_i(we_i),
    .waddr_i(waddr_i), .winst_i(winst_i), .raddr_i(raddr_i),
    .hit_o(hit_o), .inst_o(inst_o)
  );

  int checks = 0;
  int failures = 0;

  int          m_n [SETS];
  logic [31:0] m_a [SETS][2];
  logic [31:0] m_d [SETS][2];

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 2) % SETS);
  endfunction

  function automatic int find(input logic [31:0] a);
    int s = set_of(a);
    for (int i = 0; i < m_n[s]; i++)
      if (m_a[s][i] == (a & 32'hFFFF_FFFC)) return i;
    return -1;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < SETS; s++) m_n[s] = 0;
  endtask

  // Make entry i the most recently used one
  task automatic touch(input int s, input int i);
    logic [31:0] ta, td;
    if (i == 0 && m_n[s] == 2) begin
      ta = m_a[s][0]; td = m_d[s][0];
      m_a[s][0] = m_a[s][1]; m_d[s][0] = m_d[s][1];
      m_a[s][1] = ta; m_d[s][1] = td;
    end
  endtask

  task automatic m_fill(input logic [31:0] a, input logic [31:0] d);
    int s = set_of(a);
    int i = find(a);
    if (i >= 0) begin
      m_d[s][i] = d;
      touch(s, i);
    end else if (m_n[s] < 2) begin
      m_a[s][m_n[s]] = a & 32'hFFFF_FFFC;
      m_d[s][m_n[s]] = d;
      m_n[s]++;
    end else begin
      m_a[s][0] = m_a[s][1]; m_d[s][0] = m_d[s][1];
      m_a[s][1] = a & 32'hFFFF_FFFC; m_d[s][1] = d;
    end
  endtask

  // One clock cycle: drive, check lookup against model (and optional constants), advance
  task automatic step(input logic fl, input logic we, input logic [31:0] wa,
                      input logic [31:0] wd, input logic [31:0] ra, input string tag,
                      input bit chk_const, input logic exp_h, input logic [31:0] exp_i);
    int s, i;
    logic mh;
    logic [31:0] mi;
    flush_i = fl; we_i = we; waddr_i = wa; winst_i = wd; raddr_i = ra;
    #2;
    s  = set_of(ra);
    i  = find(ra);
    mh = (i >= 0);
    mi = mh ? m_d[s][i] : 32'h0;
    checks++;
    assert (hit_o === mh) else begin
      failures++;
      $error("FAIL %s hit_o observed=%0b expected=%0b", tag, hit_o, mh);
    end
    checks++;
    assert (inst_o === mi) else begin
      failures++;
      $error("FAIL %s inst_o observed=%h expected=%h", tag, inst_o, mi);
    end
    if (chk_const) begin
      checks++;
      assert (hit_o === exp_h) else begin
        failures++;
        $error("FAIL %s hit_o(directed) observed=%0b expected=%0b", tag, hit_o, exp_h);
      end
      checks++;
      assert (inst_o === exp_i) else begin
        failures++;
        $error("FAIL %s inst_o(directed) observed=%h expected=%h", tag, inst_o, exp_i);
      end
    end
    @(posedge clk);
    if (fl) m_clear();
    else begin
      if (we) m_fill(wa, wd);
      if (mh && !(we && set_of(wa) == s)) touch(s, i);
    end
    #1;
    flush_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d, input string tag);
    step(1'b0, 1'b1, a, d, IDLE, tag, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic probe(input logic [31:0] a, input logic h, input logic [31:0] d, input string tag);
    step(1'b0, 1'b0, 32'h0, 32'h0, a, tag, 1'b1, h, d);
  endtask

  task automatic do_flush();
    step(1'b1, 1'b0, 32'h0, 32'h0, IDLE, "flush", 1'b0, 1'b0, 32'h0);
  endtask

  // Reset cycle, possibly with a fill that must be lost
  task automatic do_reset(input logic we, input logic [31:0] wa, input logic [31:0] wd);
    rst = 1'b1; we_i = we; waddr_i = wa; winst_i = wd;
    @(posedge clk);
    m_clear();
    #1;
    rst = 1'b0; we_i = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
    if ($urandom_range(0, 15) == 0) a = a | ($urandom & 32'hFFFF_0000);
    return a;
  endfunction

  initial begin
    logic [31:0] ra;
    rst = 1'b1; flush_i = 1'b0; we_i = 1'b0;
    waddr_i = 32'h0; winst_i = 32'h0; raddr_i = IDLE;
    m_clear();
    @(posedge clk); #1;
    do_reset(1'b0, 32'h0, 32'h0);

    probe(32'h0000_1000, 1'b0, 32'h0, "reset_lookup");

    step(1'b0, 1'b1, 32'h1000, 32'h93, 32'h1000, "fill_same_cycle", 1'b1, 1'b0, 32'h0);
    probe(32'h1000, 1'b1, 32'h93, "fill_next_cycle");
    do_flush();

    fill(32'h1000, 32'h11, "evict_f1");
    fill(32'h1100, 32'h22, "evict_f2");
    fill(32'h1200, 32'h33, "evict_f3");
    probe(32'h1100, 1'b1, 32'h22, "evict_1100");
    probe(32'h1200, 1'b1, 32'h33, "evict_1200");
    probe(32'h1000, 1'b0, 32'h0,  "evict_1000");
    do_flush();

    fill(32'h1000, 32'h11, "lru_f1");
    fill(32'h1100, 32'h22, "lru_f2");
    probe(32'h1000, 1'b1, 32'h11, "lru_hold1");
    probe(32'h1000, 1'b1, 32'h11, "lru_hold2");
    fill(32'h1200, 32'h33, "lru_f3");
    probe(32'h1100, 1'b0, 32'h0,  "lru_1100_gone");
    probe(32'h1000, 1'b1, 32'h11, "lru_1000");
    probe(32'h1200, 1'b1, 32'h33, "lru_1200");
    do_flush();

    fill(32'h1000, 32'h13, "dup_f1");
    fill(32'h1000, 32'h13, "dup_f2");
    fill(32'h1000, 32'h13, "dup_f3");
    fill(32'h1100, 32'h22, "dup_f4");
    probe(32'h1000, 1'b1, 32'h13, "dup_1000");
    probe(32'h1100, 1'b1, 32'h22, "dup_1100");
    do_flush();

    fill(32'h2000, 32'h44, "fl_f1");
    step(1'b1, 1'b1, 32'h3000, 32'h55, IDLE, "fl_with_fill", 1'b0, 1'b0, 32'h0);
    probe(32'h2000, 1'b0, 32'h0,  "fl_2000");
    probe(32'h3000, 1'b0, 32'h0,  "fl_3000");
    fill(32'h2000, 32'h66, "fl_refill");
    probe(32'h2000, 1'b1, 32'h66, "fl_2000_again");

    do_reset(1'b1, 32'h2100, 32'h77);
    probe(32'h2000, 1'b0, 32'h0, "rst_2000");
    probe(32'h2100, 1'b0, 32'h0, "rst_fill_lost");

    // Random traffic: held or changing lookup address, fills, rare flush/reset
    ra = rand_addr();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 1) == 0) ra = rand_addr() | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0)
        do_reset($urandom_range(0, 1) == 1, rand_addr(), $urandom);
      else
        step($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, rand_addr(),
             $urandom, ra, "random", 1'b0, 1'b0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
